// File: rtl/sierpinski_pattern_gen_if.sv
// rtl/sierpinski_pattern_gen_if.sv - control and row bus between row timing, generator and serialiser
interface sierpinski_pattern_gen_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             en;
   logic [1:0]       mode;
   logic             load;
   logic [WIDTH-1:0] load_data;
   logic [WIDTH-1:0] state_out;
   logic             step_valid;
   logic             wrap;
   logic [CNT_W-1:0] period;
   logic             lock_recover;
   logic             dead;

   modport master (
      output en, mode, load, load_data,
      input  state_out, step_valid, wrap, period, lock_recover, dead
   );

   modport slave (
      input  en, mode, load, load_data,
      output state_out, step_valid, wrap, period, lock_recover, dead
   );
endinterface

// File: rtl/sierpinski_pattern_gen.sv
// rtl/sierpinski_pattern_gen.sv - LFSR / rule-90 row generator with seed load, lock-up recovery and period measurement
module sierpinski_pattern_gen #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
   parameter logic [WIDTH-1:0] POLY  = 8'h71,
   parameter logic [WIDTH-1:0] SEED  = 8'h01,
   parameter int               CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   sierpinski_pattern_gen_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] r_state;
   logic [WIDTH-1:0] r_anchor;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_period;
   logic [1:0]       r_mode;
   logic             r_step_valid;
   logic             r_wrap;
   logic             r_lock;

   logic             w_fib_fb;
   logic [WIDTH-1:0] w_fib_next;
   logic [WIDTH-1:0] w_gal_next;
   logic [WIDTH-1:0] w_ca_null;
   logic [WIDTH-1:0] w_ca_wrap;
   logic [WIDTH-1:0] w_next;
   logic             w_mode_chg;
   logic             w_zero_lock;
   logic [WIDTH-1:0] w_base_anchor;
   logic [CNT_W-1:0] w_base_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_hit;

   assign w_fib_fb   = ^(r_state & TAPS);
   assign w_fib_next = {r_state[WIDTH-2:0], w_fib_fb};
   assign w_gal_next = {r_state[WIDTH-2:0], 1'b0} ^ (r_state[WIDTH-1] ? POLY : '0);

   // Rule 90: each cell becomes the XOR of its two neighbours; edges differ only in the missing neighbour
   for (genvar i = 0; i < WIDTH; i++) begin : g_ca
      if (i == 0) begin : g_lo
         assign w_ca_null[i] = r_state[1];
         assign w_ca_wrap[i] = r_state[1] ^ r_state[WIDTH-1];
      end else if (i == WIDTH - 1) begin : g_hi
         assign w_ca_null[i] = r_state[WIDTH-2];
         assign w_ca_wrap[i] = r_state[WIDTH-2] ^ r_state[0];
      end else begin : g_mid
         assign w_ca_null[i] = r_state[i-1] ^ r_state[i+1];
         assign w_ca_wrap[i] = r_state[i-1] ^ r_state[i+1];
      end
   end

   always_comb begin
      w_next = w_fib_next;
      case (bus.mode)
         2'd0:    w_next = w_fib_next;
         2'd1:    w_next = w_gal_next;
         2'd2:    w_next = w_ca_null;
         default: w_next = w_ca_wrap;
      endcase
   end

   // A mode change re-anchors on the current row, so a step on the same edge counts as step 1
   assign w_mode_chg    = (bus.mode != r_mode);
   assign w_base_anchor = w_mode_chg ? r_state : r_anchor;
   assign w_base_cnt    = w_mode_chg ? '0 : r_cnt;
   assign w_cnt_inc     = (w_base_cnt == CNT_MAX) ? CNT_MAX : w_base_cnt + CNT_W'(1);
   assign w_hit         = (w_next == w_base_anchor);
   assign w_zero_lock   = ~bus.mode[1] && (r_state == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= SEED;
         r_anchor     <= SEED;
         r_cnt        <= '0;
         r_period     <= '0;
         r_mode       <= 2'd0;
         r_step_valid <= 1'b0;
         r_wrap       <= 1'b0;
         r_lock       <= 1'b0;
      end else begin
         r_mode       <= bus.mode;
         r_step_valid <= 1'b0;
         r_wrap       <= 1'b0;
         r_lock       <= 1'b0;
         if (bus.load) begin
            r_state  <= bus.load_data;
            r_anchor <= bus.load_data;
            r_cnt    <= '0;
         end else if (bus.en) begin
            r_step_valid <= 1'b1;
            if (w_zero_lock) begin
               // An all-zero LFSR would never leave zero; restart the sequence from the seed
               r_state  <= SEED;
               r_anchor <= SEED;
               r_cnt    <= '0;
               r_lock   <= 1'b1;
            end else begin
               r_state  <= w_next;
               r_anchor <= w_base_anchor;
               if (w_hit) begin
                  r_period <= w_cnt_inc;
                  r_wrap   <= 1'b1;
                  r_cnt    <= '0;
               end else begin
                  r_cnt    <= w_cnt_inc;
               end
            end
         end else begin
            r_anchor <= w_base_anchor;
            r_cnt    <= w_base_cnt;
         end
      end
   end

   assign bus.state_out    = r_state;
   assign bus.step_valid   = r_step_valid;
   assign bus.wrap         = r_wrap;
   assign bus.period       = r_period;
   assign bus.lock_recover = r_lock;
   assign bus.dead         = bus.mode[1] && (r_state == '0);

endmodule

// File: tb/tb_sierpinski_pattern_gen.sv
// tb/tb_sierpinski_pattern_gen.sv - vector table, corner sequences and randomized model check for sierpinski_pattern_gen
module tb_sierpinski_pattern_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   sierpinski_pattern_gen_if #(.WIDTH(8), .CNT_W(16)) bus ();

   sierpinski_pattern_gen #(
      .WIDTH(8), .TAPS(8'hB8), .POLY(8'h71), .SEED(8'h01), .CNT_W(16)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic       ld;
      logic [7:0] ld_data;
      logic       en;
      logic [1:0] mode;
      logic [7:0] exp_state;
      logic       exp_sv;
      logic       exp_wrap;
      logic       exp_lock;
      logic       exp_dead;
   } vec_t;

   vec_t vt[18];

   // reference model state
   logic [7:0] m_state, m_anchor;
   int         m_cnt, m_period;
   logic [1:0] m_mode;
   logic       m_sv, m_wrap, m_lock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic ld, input logic [7:0] d, input logic e, input logic [1:0] m);
      @(negedge clk);
      bus.load = ld;
      bus.load_data = d;
      bus.en = e;
      bus.mode = m;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.load = 1'b0;
      bus.en = 1'b0;
      bus.mode = 2'd0;
      bus.load_data = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      m_state = 8'h01; m_anchor = 8'h01; m_cnt = 0; m_period = 0;
      m_mode = 2'd0; m_sv = 0; m_wrap = 0; m_lock = 0;
   endtask

   function automatic logic [7:0] ref_next(input logic [7:0] s, input logic [1:0] m);
      int v;
      v = int'(s);
      case (m)
         2'd0:    return 8'(((v * 2) % 256) + ($countones(s & 8'hB8) % 2));
         2'd1:    return 8'(((v * 2) % 256) ^ ((v >= 128) ? 'h71 : 0));
         2'd2:    return 8'((v * 2) ^ (v / 2));
         default: return 8'(((v * 2) % 256 + v / 128) ^ (v / 2 + (v % 2) * 128));
      endcase
   endfunction

   task automatic model_edge(input logic ld, input logic [7:0] d, input logic e, input logic [1:0] m);
      logic [7:0] base_anchor, nxt;
      int base_cnt, c;
      base_anchor = m_anchor;
      base_cnt = m_cnt;
      if (m != m_mode) begin
         base_anchor = m_state;
         base_cnt = 0;
      end
      m_sv = 0; m_wrap = 0; m_lock = 0;
      if (ld) begin
         m_state = d; m_anchor = d; m_cnt = 0;
      end else if (e) begin
         m_sv = 1;
         if (m < 2 && m_state == 8'h00) begin
            m_state = 8'h01; m_anchor = 8'h01; m_cnt = 0; m_lock = 1;
         end else begin
            nxt = ref_next(m_state, m);
            c = (base_cnt + 1 > 65535) ? 65535 : base_cnt + 1;
            m_anchor = base_anchor;
            if (nxt == base_anchor) begin
               m_period = c; m_wrap = 1; m_cnt = 0;
            end else begin
               m_cnt = c;
            end
            m_state = nxt;
         end
      end else begin
         m_anchor = base_anchor;
         m_cnt = base_cnt;
      end
      m_mode = m;
   endtask

   initial begin
      int wraps;
      logic       r_ld, r_en;
      logic [7:0] r_d;
      logic [1:0] r_m;

      vt[0]  = '{1'b0, 8'h00, 1'b1, 2'd0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{1'b0, 8'h00, 1'b1, 2'd0, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[2]  = '{1'b0, 8'h00, 1'b1, 2'd0, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[3]  = '{1'b0, 8'h00, 1'b1, 2'd0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[4]  = '{1'b1, 8'h80, 1'b0, 2'd1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[5]  = '{1'b0, 8'h00, 1'b1, 2'd1, 8'h71, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[6]  = '{1'b1, 8'h10, 1'b0, 2'd2, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[7]  = '{1'b0, 8'h00, 1'b1, 2'd2, 8'h28, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[8]  = '{1'b0, 8'h00, 1'b1, 2'd2, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[9]  = '{1'b0, 8'h00, 1'b1, 2'd2, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[10] = '{1'b0, 8'h00, 1'b1, 2'd2, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[11] = '{1'b1, 8'hAA, 1'b0, 2'd3, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[12] = '{1'b0, 8'h00, 1'b1, 2'd3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
      vt[13] = '{1'b0, 8'h00, 1'b1, 2'd3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
      vt[14] = '{1'b1, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[15] = '{1'b0, 8'h00, 1'b1, 2'd0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[16] = '{1'b1, 8'h5A, 1'b1, 2'd0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[17] = '{1'b0, 8'h00, 1'b0, 2'd0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0};

      do_reset();
      #1;
      chk("reset_state", 64'(bus.state_out), 64'h01);
      chk("reset_flags", 64'({bus.step_valid, bus.wrap, bus.lock_recover, bus.dead}), 64'h0);
      chk("reset_period", 64'(bus.period), 64'h0);

      for (int i = 0; i < 18; i++) begin
         cyc(vt[i].ld, vt[i].ld_data, vt[i].en, vt[i].mode);
         chk($sformatf("vec%0d", i),
             64'({bus.state_out, bus.step_valid, bus.wrap, bus.lock_recover, bus.dead}),
             64'({vt[i].exp_state, vt[i].exp_sv, vt[i].exp_wrap, vt[i].exp_lock, vt[i].exp_dead}));
      end

      // full Fibonacci period from reset, two laps
      do_reset();
      wraps = 0;
      for (int i = 1; i <= 510; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 2'd0);
         if (bus.wrap) wraps++;
         if (i == 255) begin
            chk("fib_lap_state", 64'(bus.state_out), 64'h01);
            chk("fib_lap_wrap", 64'(bus.wrap), 64'h1);
            chk("fib_period", 64'(bus.period), 64'd255);
         end
      end
      chk("fib_wrap_count", 64'(wraps), 64'd2);

      // Galois period from a loaded anchor
      cyc(1'b1, 8'h80, 1'b0, 2'd1);
      wraps = 0;
      for (int i = 1; i <= 255; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 2'd1);
         if (bus.wrap) wraps++;
      end
      chk("gal_state", 64'(bus.state_out), 64'h80);
      chk("gal_wrap_last", 64'(bus.wrap), 64'h1);
      chk("gal_period", 64'(bus.period), 64'd255);
      chk("gal_wrap_count", 64'(wraps), 64'd1);

      // mode change while dead re-anchors on zero, so the same-edge step wraps with period 1
      cyc(1'b1, 8'hAA, 1'b0, 2'd3);
      cyc(1'b0, 8'h00, 1'b1, 2'd3);
      cyc(1'b0, 8'h00, 1'b1, 2'd2);
      chk("mchg_state_wrap_lock", 64'({bus.state_out, bus.wrap, bus.lock_recover, bus.dead}),
          64'({8'h00, 1'b1, 1'b0, 1'b1}));
      chk("mchg_period", 64'(bus.period), 64'd1);

      // asynchronous reset mid-run
      cyc(1'b1, 8'h37, 1'b0, 2'd0);
      cyc(1'b0, 8'h00, 1'b1, 2'd0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_state", 64'(bus.state_out), 64'h01);
      chk("arst_flags", 64'({bus.step_valid, bus.wrap, bus.lock_recover, bus.dead}), 64'h0);
      chk("arst_period", 64'(bus.period), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.en = 1'b1;
      bus.load = 1'b0;
      bus.mode = 2'd0;
      @(posedge clk);
      #1;
      chk("arst_first_step", 64'({bus.state_out, bus.step_valid}), 64'({8'h02, 1'b1}));

      // randomized run against the reference model
      do_reset();
      r_m = 2'd0;
      for (int i = 0; i < 3000; i++) begin
         r_ld = ($urandom_range(0, 19) == 0);
         r_d  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         r_en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 29) == 0) r_m = 2'($urandom);
         cyc(r_ld, r_d, r_en, r_m);
         model_edge(r_ld, r_d, r_en, r_m);
         chk($sformatf("rand%0d", i),
             64'({bus.state_out, bus.step_valid, bus.wrap, bus.lock_recover, bus.dead, bus.period}),
             64'({m_state, m_sv, m_wrap, m_lock, (m_state == 8'h00 && r_m >= 2'd2), 16'(m_period)}));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sierpinski_pattern_gen.md
# sierpinski_pattern_gen

Parametrised row generator for the Sierpinski pattern datapath. It generalises the fixed 8-bit LFSR row source to any width and adds runtime-selectable Fibonacci LFSR, Galois LFSR and rule-90 cellular-automaton modes. It also provides seed loading, all-zero lock-up recovery and cycle-period measurement. It sits between the row-timing controller, which drives `en` once per displayed row, and the pixel serialiser, which consumes `state_out`.

## Interface
Parameters:
- `WIDTH`, 8: state/row width in bits; legal range ≥ 3.
- `TAPS`, 8'hB8: Fibonacci tap mask; bit k set means `state[k]` enters the XOR feedback. Default is x^8+x^6+x^5+x^4+1.
- `POLY`, 8'h71: Galois feedback mask; XORed into the shifted state when the bit shifted out is 1.
- `SEED`, 8'h01: reset value, and the recovery value for lock-up.
- `CNT_W`, 16: width of the period counter and of `period`.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `en`, in, 1: advance the state by one step on this edge.
- `mode`, in, 2: 0 = Fibonacci, 1 = Galois, 2 = rule 90 with null boundaries, 3 = rule 90 with periodic (wrap) boundaries.
- `load`, in, 1: replace the state with `load_data`.
- `load_data`, in, WIDTH: value to load.
- `state_out`, out, WIDTH: current row; this is a register.
- `step_valid`, out, 1: one-cycle pulse meaning `state_out` advanced on the previous edge.
- `wrap`, out, 1: one-cycle pulse meaning the last step returned the state to the anchor.
- `period`, out, CNT_W: step count of the most recently completed cycle.
- `lock_recover`, out, 1: one-cycle pulse meaning the last step performed zero-lock recovery.
- `dead`, out, 1: high while `state_out` == 0 in a CA mode (mode 2 or 3).

## Operation
Next-state functions, where `s` is the current state:
- Mode 0 (Fibonacci): `fb = ^(s & TAPS)`; next = `{s[WIDTH-2:0], fb}`.
- Mode 1 (Galois): next = `(s << 1) ^ (s[WIDTH-1] ? POLY : 0)`.
- Mode 2 (rule 90, null boundaries): `next[i] = s[i-1] ^ s[i+1]`; out-of-range neighbours read as 0.
- Mode 3 (rule 90, periodic): same rule, with indices taken modulo WIDTH.

Update priority on each edge:
1. `load` is highest. State becomes `load_data` and `en` is ignored. The anchor becomes `load_data` and the counter clears. No `step_valid` follows.
2. Otherwise, if `en` is high, the state steps.
3. Otherwise the state holds.

Rules for a step:
- **Zero-lock recovery.** Applies in mode 0 or 1 when `s` == 0. The state becomes `SEED` instead of the computed value. The anchor becomes `SEED`, the counter clears and `lock_recover` pulses. `wrap` does not pulse.
- **CA dead state.** In mode 2 or 3, zero is a legal absorbing state. It is held with no recovery, and `dead` is high while it persists.
- **Period counter.** Increments on every step and saturates at 2^CNT_W−1. If the next state equals the anchor, `period` <= counter+1 (saturated), `wrap` pulses and the counter clears.
- **Mode change.** The block registers `mode`. Any step or idle edge where `mode` differs from its registered value re-anchors: the anchor becomes the current state and the counter clears. This does not alter the state. A step on the same edge uses the new mode and counts as step 1.
- **Load of zero in mode 0 or 1.** Accepted. The next enabled step recovers to `SEED`.

## Timing
- Reset values:
  - `state_out` = SEED; the anchor = SEED.
  - The counter = 0; `period` = 0.
  - `step_valid`, `wrap` and `lock_recover` = 0.
  - `dead` = 0.
  - The registered mode = 0.
- Latency:
  - `en` or `load` sampled at edge N gives the new `state_out` after edge N.
  - `step_valid`, `wrap` and `lock_recover` are high during the cycle after edge N only.
  - `dead` is combinational from `state_out` and the current `mode`.
- With `en` held high, the block produces one step per cycle with no bubbles.
- Reset mid-operation clears everything immediately (asynchronously) to the reset values. The first step is allowed on the first edge after `rst_n` deasserts.

## Test plan
- **Reset and Fibonacci stepping.** Release reset, mode 0, `en` high for 4 cycles -> `state_out` 0x01, then 0x02, 0x04, 0x08, 0x11; `step_valid` high for 4 cycles.
- **Full Fibonacci period.** Mode 0, `en` high for 255 steps -> state back to 0x01, `wrap` pulses once on step 255, `period` = 255; after 510 steps, exactly 2 `wrap` pulses.
- **Galois.** Load 0x80 in mode 1, one step -> 0x71. Continue 255 steps from the load -> `wrap` pulses with `period` = 255.
- **Rule 90, null boundaries.** Load 0x10 in mode 2, step 4 times -> 0x28, 0x44, 0xAA, 0x01; `dead` stays low.
- **Rule 90, periodic boundaries.** Load 0xAA in mode 3, one step -> 0x00 and `dead` high. A further step holds 0x00 with no `lock_recover`.
- **Zero lock and load priority.**
  - Load 0x00 in mode 0, then step -> state 0x01 and `lock_recover` pulses.
  - Assert `load` (load_data 0x5A) and `en` together -> state 0x5A with no `step_valid`.
  - Assert reset mid-run -> all outputs return to their reset values.
